// File: rtl/reg_wb_sched_if.sv
// Write-back scheduler bundle: issue check, ALU/LSU write-back, RF write port.
// Optional byp1/byp2 exist only under REG_WB_SCHED_BYPASS_EN.
interface reg_wb_sched_if #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 32
);
   logic            iss_valid;
   logic [AW-1:0]   iss_rs1;
   logic [AW-1:0]   iss_rs2;
   logic [AW-1:0]   iss_rd;
   logic            iss_ready;
   logic            alu_valid;
   logic [AW-1:0]   alu_wa;
   logic [DW-1:0]   alu_wd;
   logic            alu_ready;
   logic            lsu_valid;
   logic [AW-1:0]   lsu_wa;
   logic [DW-1:0]   lsu_wd;
   logic            lsu_ready;
   logic            rf_we;
   logic [AW-1:0]   rf_wa;
   logic [DW-1:0]   rf_wd;
   logic [NREG-1:0] busy;
   logic            wb_err;
`ifdef REG_WB_SCHED_BYPASS_EN
   logic            byp1;
   logic            byp2;
`endif

   modport slave (
`ifdef REG_WB_SCHED_BYPASS_EN
      output byp1, byp2,
`endif
      input  iss_valid, iss_rs1, iss_rs2, iss_rd,
      output iss_ready,
      input  alu_valid, alu_wa, alu_wd,
      output alu_ready,
      input  lsu_valid, lsu_wa, lsu_wd,
      output lsu_ready,
      output rf_we, rf_wa, rf_wd, busy, wb_err
   );

   modport master (
`ifdef REG_WB_SCHED_BYPASS_EN
      input  byp1, byp2,
`endif
      output iss_valid, iss_rs1, iss_rs2, iss_rd,
      input  iss_ready,
      output alu_valid, alu_wa, alu_wd,
      input  alu_ready,
      output lsu_valid, lsu_wa, lsu_wd,
      input  lsu_ready,
      input  rf_we, rf_wa, rf_wd, busy, wb_err
   );
endinterface

// File: rtl/reg_wb_sched.sv
// Write-back arbiter (ALU/LSU round-robin) and register hazard scoreboard.
// REG_WB_SCHED_BYPASS_EN adds byp1/byp2 and relaxes rs hazards on bypass.
module reg_wb_sched #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input logic            clk,
   input logic            rst,
   reg_wb_sched_if.slave  bus
);

   logic [NREG-1:0] busy_q, busy_d;
   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_wa_q, rf_wa_d;
   logic [DW-1:0]   rf_wd_q, rf_wd_d;
   logic            err_q, err_d;
   logic            last_lsu_q, last_lsu_d;

   logic            hz_rs1, hz_rs2, hz_rd;
   logic            hazard, iss_acc;
   logic            gnt_alu, gnt_lsu, gnt;
   logic [AW-1:0]   g_wa;
   logic [DW-1:0]   g_wd;

`ifdef REG_WB_SCHED_BYPASS_EN
   logic byp1, byp2;

   // Data committing this cycle can feed a source operand directly.
   assign byp1 = rf_we_q & (rf_wa_q == bus.iss_rs1)
               & (bus.iss_rs1 != '0);
   assign byp2 = rf_we_q & (rf_wa_q == bus.iss_rs2)
               & (bus.iss_rs2 != '0);
   assign bus.byp1 = byp1;
   assign bus.byp2 = byp2;
   assign hz_rs1 = busy_q[bus.iss_rs1] & ~byp1;
   assign hz_rs2 = busy_q[bus.iss_rs2] & ~byp2;
`else
   assign hz_rs1 = busy_q[bus.iss_rs1];
   assign hz_rs2 = busy_q[bus.iss_rs2];
`endif

   assign hz_rd  = busy_q[bus.iss_rd];
   assign hazard = hz_rs1 | hz_rs2 | hz_rd;
   assign iss_acc = bus.iss_valid & ~hazard;

   // On conflict the source that did not win last time is granted.
   assign gnt_alu = bus.alu_valid & (~bus.lsu_valid | last_lsu_q);
   assign gnt_lsu = bus.lsu_valid & (~bus.alu_valid | ~last_lsu_q);
   assign gnt     = gnt_alu | gnt_lsu;
   assign g_wa    = gnt_alu ? bus.alu_wa : bus.lsu_wa;
   assign g_wd    = gnt_alu ? bus.alu_wd : bus.lsu_wd;

   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) busy_d[rf_wa_q] = 1'b0;
      if (iss_acc && bus.iss_rd != '0) busy_d[bus.iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      rf_we_d    = gnt & (g_wa != '0);
      rf_wa_d    = rf_we_d ? g_wa : rf_wa_q;
      rf_wd_d    = rf_we_d ? g_wd : rf_wd_q;
      err_d      = err_q | (rf_we_d & ~busy_q[g_wa]);
      last_lsu_d = gnt ? gnt_lsu : last_lsu_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q     <= '0;
         rf_we_q    <= 1'b0;
         rf_wa_q    <= '0;
         rf_wd_q    <= '0;
         err_q      <= 1'b0;
         last_lsu_q <= 1'b1;
      end else begin
         busy_q     <= busy_d;
         rf_we_q    <= rf_we_d;
         rf_wa_q    <= rf_wa_d;
         rf_wd_q    <= rf_wd_d;
         err_q      <= err_d;
         last_lsu_q <= last_lsu_d;
      end
   end

   assign bus.iss_ready = ~hazard;
   assign bus.alu_ready = gnt_alu;
   assign bus.lsu_ready = gnt_lsu;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_wa     = rf_wa_q;
   assign bus.rf_wd     = rf_wd_q;
   assign bus.busy      = busy_q;
   assign bus.wb_err    = err_q;

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Write-back scheduler and hazard scoreboard in front of the 32x32 register file.
- Arbitrates the single register-file write port between the ALU and LSU write-back sources.
- Tracks which registers have an in-flight producer and withholds issue of instructions whose operands or destination are pending.
- Sits between the decode/issue stage, the execute units, and the register file write port.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately when low.
- iss_valid  in  1  decode presents an instruction.
- iss_rs1  in  AW  source register 1 address.
- iss_rs2  in  AW  source register 2 address.
- iss_rd  in  AW  destination register address; 0 means no write-back.
- iss_ready  out  1  instruction may issue this cycle.
- alu_valid  in  1  ALU write-back request.
- alu_wa  in  AW  ALU write address.
- alu_wd  in  DW  ALU write data.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU write-back request.
- lsu_wa  in  AW  LSU write address.
- lsu_wd  in  DW  LSU write data.
- lsu_ready  out  1  LSU request accepted this cycle.
- rf_we  out  1  register-file write enable.
- rf_wa  out  AW  register-file write address.
- rf_wd  out  DW  register-file write data.
- busy  out  NREG  scoreboard vector; bit i set means register i has a pending producer.
- wb_err  out  1  sticky error flag.

Behaviour:
- Reset (rst low, asynchronous): busy = 0, rf_we = 0, rf_wa = 0, rf_wd = 0, wb_err = 0, last_grant = LSU (so the ALU wins the first conflict).
- Issue check (combinational):
  - hazard = busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd].
  - busy[0] is constant 0.
  - iss_ready = ~hazard; independent of iss_valid.
  - Issue is accepted when iss_valid & iss_ready at a posedge.
- Scoreboard:
  - Set: on issue accept with iss_rd != 0, busy[iss_rd] <= 1.
  - Clear: busy[rf_wa] <= 0 on any posedge where rf_we = 1, i.e. the same edge the register file commits the data.
  - Set and clear of the same register on the same edge: set wins.
- Arbitration (combinational grant, round-robin):
  - Only one source valid: that source is granted.
  - Both valid: grant the source not equal to last_grant.
  - alu_ready = alu_valid & grant_alu; lsu_ready = lsu_valid & grant_lsu; never both high.
  - last_grant updates only on an actual grant.
- Write stage (registered, latency 1):
  - Request accepted at edge N drives rf_we/rf_wa/rf_wd throughout cycle N+1.
  - Register file commits at edge N+1.
  - A consumer may issue in cycle N+2 at the earliest without bypass.
  - rf_we <= 1 only if a grant occurred and the granted address != 0.
  - A write to register 0 is accepted (ready high) and discarded: rf_we stays 0 and wb_err is not set.
  - When no grant occurs, rf_we <= 0; rf_wa/rf_wd hold their previous values.
- Error: wb_err sets, and stays set until reset, when an accepted write-back targets a nonzero register whose busy bit is 0 at the accept edge.
- Reset mid-operation: the in-flight write in the output stage is dropped and all busy bits clear. Register-file contents are not this block's responsibility.

Optional Feature:
- Macro REG_WB_SCHED_BYPASS_EN.
- When defined:
  - Adds outputs byp1 (1) and byp2 (1).
  - byp1 = rf_we & (rf_wa == iss_rs1) & (iss_rs1 != 0); byp2 is the same against iss_rs2.
  - The hazard term for an rs operand matching a bypassed address is suppressed, so the consumer issues in cycle N+1 and selects rf_wd.
  - An rd-based hazard is never suppressed.
- When undefined: no byp ports; hazard is exactly as specified above.

Test Plan:
- Issue rd=5; next cycle issue rs1=5 -> second issue sees iss_ready=0.
- Then ALU writes 5 / 0xDEADBEEF -> rf_we=1, rf_wa=5 one cycle later; busy[5]=0 after that edge; iss_ready=1 the following cycle (one cycle earlier with BYPASS_EN, byp1=1).
- ALU and LSU valid on the same cycle from reset, repeated 4 cycles -> grants alternate ALU, LSU, ALU, LSU; alu_ready and lsu_ready never both high.
- Issue rd=0, then LSU writes addr 0 data 0x1234 -> lsu_ready=1, rf_we stays 0, busy stays 0, wb_err stays 0.
- ALU writes register 7 while busy[7]=0 -> wb_err=1 and remains 1 until rst low.
- Write-back clearing register 9 on the same edge a new rd=9 issue is accepted -> busy[9]=1 after the edge.
- rst low mid-cycle with busy=0x0000_0120 and rf_we=1 -> busy=0 and rf_we=0 immediately, without waiting for a clock edge.
